// File: rtl/md_pkg.sv
// md_pkg: shared op encoding and default latencies for the multiply/divide unit
package md_pkg;
    localparam int MD_OP_W         = 3;
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    typedef enum logic [MD_OP_W-1:0] {
        MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO
    } md_op_e;
endpackage

// File: rtl/md_if.sv
// md_if: E-stage command and HI/LO result bundle for md_unit
interface md_if #(parameter int WIDTH = 32);
    import md_pkg::*;
    logic             start;
    md_op_e           md_op;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    modport master (output start, md_op, rs_data, rt_data, input busy, done, hi, lo);
    modport slave (input start, md_op, rs_data, rt_data, output busy, done, hi, lo);
endinterface

// File: rtl/md_arith.sv
// md_arith: combinational signed/unsigned multiply and divide with divide-by-zero rule
module md_arith import md_pkg::*; #(parameter int WIDTH = 32) (
    input  md_op_e           op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    logic               is_signed, is_div, neg_a, neg_b;
    logic [2*WIDTH-1:0] ea, eb, prod;
    logic [WIDTH-1:0]   ma, mb, uq, ur, q, r;
    // Signed divide runs on magnitudes; MIN/-1 then wraps to MIN with remainder 0.
    always_comb begin
        is_signed = op inside {MD_MULT, MD_DIV};
        is_div    = op inside {MD_DIV, MD_DIVU};
        ea        = is_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        eb        = is_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        prod      = ea * eb;
        neg_a     = is_signed && a[WIDTH-1];
        neg_b     = is_signed && b[WIDTH-1];
        ma        = neg_a ? -a : a;
        mb        = neg_b ? -b : b;
        uq        = mb == '0 ? '0 : ma / mb;
        ur        = mb == '0 ? '0 : ma % mb;
        q         = (neg_a ^ neg_b) ? -uq : uq;
        r         = neg_a ? -ur : ur;
        hi        = !is_div ? prod[2*WIDTH-1:WIDTH] : b == '0 ? a : r;
        lo        = !is_div ? prod[WIDTH-1:0] : b == '0 ? '1 : q;
    end
endmodule

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit holding HI/LO beside the execute-stage ALU
module md_unit import md_pkg::*; #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input logic clk,
    input logic reset,
    md_if.slave bus
);
    localparam int CNT_W = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
    typedef enum logic {IDLE, RUN} state_e;
    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] hi, lo, pend_hi, pend_lo, res_hi, res_lo;
    logic             busy, done, launch, is_div;
    md_arith #(.WIDTH(WIDTH)) u_arith (
        .op(bus.md_op),
        .a(bus.rs_data),
        .b(bus.rt_data),
        .hi(res_hi),
        .lo(res_lo)
    );
    always_comb begin
        launch = bus.start && bus.md_op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
        is_div = bus.md_op inside {MD_DIV, MD_DIVU};
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch) begin
                        pend_hi <= res_hi;
                        pend_lo <= res_lo;
                        cnt     <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        busy    <= 1'b1;
                        state   <= RUN;
                    end else if (bus.md_op == MD_MTHI) begin
                        hi <= bus.rs_data;
                    end else if (bus.md_op == MD_MTLO) begin
                        lo <= bus.rs_data;
                    end
                end
                RUN: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        hi    <= pend_hi;
                        lo    <= pend_lo;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.hi   = hi;
    assign bus.lo   = lo;
    // The hazard unit should never let a command reach us while busy; it is dropped if it does.
    cmd_while_busy: assert property (@(posedge clk) disable iff (!reset)
        busy |-> !(launch || bus.md_op inside {MD_MTHI, MD_MTLO}))
        else $warning("md_unit: command ignored while busy");
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: table, directed and randomized checks of md_unit against a behavioural model
module tb_md_unit;
    import md_pkg::*;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    md_if #(.WIDTH(32)) bus();
    md_unit #(.WIDTH(32), .MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );
    always #5 clk = ~clk;
    typedef struct {
        md_op_e      op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;
    vec_t vecs[10];
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask
    function automatic int lat(input md_op_e op);
        return (op == MD_DIV || op == MD_DIVU) ? DIV_N : MULT_N;
    endfunction
    // Reference: 64-bit integer arithmetic straight from the op definitions.
    function automatic logic [63:0] ref_result(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            MD_MULT:  p = sa * sb;
            MD_MULTU: p = ua * ub;
            default: begin
                if (b == 32'b0) return {a, 32'hFFFF_FFFF};
                if (op == MD_DIV) begin
                    q = sa / sb;
                    r = sa - q * sb;
                end else begin
                    q = ua / ub;
                    r = ua - q * ub;
                end
                p = {r[31:0], q[31:0]};
            end
        endcase
        return p;
    endfunction
    task automatic run_op(input string tag, input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el);
        logic [31:0] oh, ol;
        int n;
        bit held, early;
        oh = bus.hi;
        ol = bus.lo;
        bus.start = 1'b1;
        bus.md_op = op;
        bus.rs_data = a;
        bus.rt_data = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.md_op = MD_NONE;
        bus.rs_data = $urandom;
        bus.rt_data = $urandom;
        n = 0;
        held = 1'b1;
        early = 1'b0;
        while (bus.busy && n < 100) begin
            if (bus.hi !== oh || bus.lo !== ol) held = 1'b0;
            if (bus.done) early = 1'b1;
            n++;
            @(negedge clk);
        end
        check({tag, " busy_cycles"}, 64'(n), 64'(lat(op)));
        check({tag, " hilo_held"}, 64'(held), 64'd1);
        check({tag, " done_early"}, 64'(early), 64'd0);
        check({tag, " done"}, 64'(bus.done), 64'd1);
        check({tag, " hi"}, 64'(bus.hi), 64'(eh));
        check({tag, " lo"}, 64'(bus.lo), 64'(el));
        @(negedge clk);
        check({tag, " done_clear"}, 64'(bus.done), 64'd0);
        m_hi = eh;
        m_lo = el;
    endtask
    task automatic mt_op(input string tag, input md_op_e op, input logic st, input logic [31:0] v);
        bus.start = st;
        bus.md_op = op;
        bus.rs_data = v;
        @(negedge clk);
        bus.start = 1'b0;
        bus.md_op = MD_NONE;
        if (op == MD_MTHI) m_hi = v;
        else m_lo = v;
        check({tag, " hi"}, 64'(bus.hi), 64'(m_hi));
        check({tag, " lo"}, 64'(bus.lo), 64'(m_lo));
        check({tag, " busy"}, 64'(bus.busy), 64'd0);
        check({tag, " done"}, 64'(bus.done), 64'd0);
    endtask
    function automatic logic [31:0] pick();
        logic [31:0] sp[5];
        sp = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF};
        return ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 4)] : $urandom;
    endfunction
    initial begin
        md_op_e op;
        logic [31:0] a, b;
        logic [63:0] r;
        int n;
        bit seen;
        vecs[0] = '{MD_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[1] = '{MD_MULTU, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE};
        vecs[2] = '{MD_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{MD_DIVU,  32'd100,       32'd0,        32'd100,       32'hFFFF_FFFF};
        vecs[4] = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000};
        vecs[5] = '{MD_DIV,   32'd7,         32'd0,        32'd7,         32'hFFFF_FFFF};
        vecs[6] = '{MD_DIVU,  32'hFFFF_FFFF, 32'd2,        32'd1,         32'h7FFF_FFFF};
        vecs[7] = '{MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
        vecs[8] = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0};
        vecs[9] = '{MD_MULTU, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0};
        bus.start = 1'b0;
        bus.md_op = MD_NONE;
        bus.rs_data = '0;
        bus.rt_data = '0;
        repeat (2) @(negedge clk);
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        check("reset hi", 64'(bus.hi), 64'd0);
        check("reset lo", 64'(bus.lo), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 10; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo);
        mt_op("mthi", MD_MTHI, 1'b0, 32'h1234);
        mt_op("mtlo_start", MD_MTLO, 1'b1, 32'h5678);
        bus.start = 1'b1;
        bus.md_op = MD_NONE;
        @(negedge clk);
        bus.start = 1'b0;
        check("nop busy", 64'(bus.busy), 64'd0);
        check("nop hilo", {bus.hi, bus.lo}, {m_hi, m_lo});
        // Commands arriving mid-run must not disturb the result or the latency.
        bus.start = 1'b1;
        bus.md_op = MD_MULT;
        bus.rs_data = 32'd3;
        bus.rt_data = 32'd5;
        @(negedge clk);
        bus.start = 1'b0;
        bus.md_op = MD_MTLO;
        bus.rs_data = 32'hDEAD;
        @(negedge clk);
        bus.start = 1'b1;
        bus.md_op = MD_DIV;
        @(negedge clk);
        bus.start = 1'b0;
        bus.md_op = MD_NONE;
        n = 2;
        while (bus.busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("busy_cmd cycles", 64'(n), 64'(MULT_N));
        check("busy_cmd done", 64'(bus.done), 64'd1);
        check("busy_cmd hi", 64'(bus.hi), 64'd0);
        check("busy_cmd lo", 64'(bus.lo), 64'd15);
        @(negedge clk);
        m_hi = 32'h0;
        m_lo = 32'd15;
        for (int i = 0; i < 40; i++) begin
            op = md_op_e'($urandom_range(1, 6));
            a = pick();
            b = pick();
            if (op == MD_MTHI || op == MD_MTLO) begin
                mt_op($sformatf("rnd%0d", i), op, 1'($urandom_range(0, 1)), a);
            end else begin
                r = ref_result(op, a, b);
                run_op($sformatf("rnd%0d", i), op, a, b, r[63:32], r[31:0]);
            end
        end
        mt_op("pre_rst", MD_MTHI, 1'b0, 32'h55);
        bus.start = 1'b1;
        bus.md_op = MD_DIV;
        bus.rs_data = 32'hFFFF_FFF9;
        bus.rt_data = 32'd2;
        @(negedge clk);
        bus.start = 1'b0;
        bus.md_op = MD_NONE;
        repeat (3) @(negedge clk);
        check("mid_run busy", 64'(bus.busy), 64'd1);
        #2 reset = 1'b0;
        #1;
        check("async_rst busy", 64'(bus.busy), 64'd0);
        check("async_rst done", 64'(bus.done), 64'd0);
        check("async_rst hi", 64'(bus.hi), 64'd0);
        check("async_rst lo", 64'(bus.lo), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen = 1'b1;
        end
        check("post_rst quiet", 64'(seen), 64'd0);
        check("post_rst hilo", {bus.hi, bus.lo}, 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
